// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 keyboard receiver: prefix/reply
// byte codes, ps2_key bit positions and the frame state encoding.
package ps2_pkg;

    localparam logic [7:0] CODE_E0 = 8'hE0;
    localparam logic [7:0] CODE_E1 = 8'hE1;
    localparam logic [7:0] CODE_F0 = 8'hF0;
    localparam logic [7:0] CODE_AA = 8'hAA;
    localparam logic [7:0] CODE_FA = 8'hFA;
    localparam logic [7:0] CODE_FE = 8'hFE;
    localparam logic [7:0] CODE_EE = 8'hEE;

    localparam int KEY_TOGGLE  = 10;
    localparam int KEY_PRESSED = 9;
    localparam int KEY_EXT     = 8;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } frame_state_e;

    // Keyboard replies and status bytes that carry no key information.
    function automatic logic isReplyByte(input logic [7:0] b);
        return (b == CODE_AA) || (b == CODE_FA) || (b == CODE_FE) ||
               (b == CODE_EE) || (b == 8'h00) || (b == 8'hFF);
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 line front end: synchroniser, clock glitch filter, 11-bit frame
// receiver with parity/start/stop checking and an inactivity timeout.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 12000
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_MAX    = TW'(TIMEOUT_CYC);

    logic [1:0]    clkSync_q, dataSync_q;
    logic          filtClk_q;
    logic [FW-1:0] filtCnt_q;
    logic          fall_q;
    logic [TW-1:0] toCnt_q;

    frame_state_e state_q, state_d;
    logic [2:0]   bitCnt_q, bitCnt_d;
    logic [7:0]   shift_q, shift_d;
    logic         parity_q, parity_d;
    logic         byteValid_q, byteValid_d;
    logic         frameErr_q, frameErr_d;
    logic         dataBit;
    logic         timeout;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            clkSync_q  <= 2'b11;
            dataSync_q <= 2'b11;
        end else begin
            clkSync_q  <= {clkSync_q[0], ps2_clk_i};
            dataSync_q <= {dataSync_q[0], ps2_data_i};
        end
    end

    // The filtered clock only follows after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            filtClk_q <= 1'b1;
            filtCnt_q <= '0;
            fall_q    <= 1'b0;
        end else begin
            fall_q <= filtClk_q & ~clkSync_q[1] & (filtCnt_q == FILT_LAST);
            if (clkSync_q[1] == filtClk_q) begin
                filtCnt_q <= '0;
            end else if (filtCnt_q == FILT_LAST) begin
                filtClk_q <= clkSync_q[1];
                filtCnt_q <= '0;
            end else begin
                filtCnt_q <= filtCnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            toCnt_q <= '0;
        end else if (fall_q) begin
            toCnt_q <= '0;
        end else if (toCnt_q != TO_MAX) begin
            toCnt_q <= toCnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            bitCnt_q    <= '0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            byteValid_q <= 1'b0;
            frameErr_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bitCnt_q    <= bitCnt_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            byteValid_q <= byteValid_d;
            frameErr_q  <= frameErr_d;
        end
    end

    assign dataBit = dataSync_q[1];
    assign timeout = (toCnt_q == TO_MAX) && (state_q != IDLE);

    // A fall strobe always takes priority over a coincident timeout.
    always_comb begin
        state_d     = state_q;
        bitCnt_d    = bitCnt_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        byteValid_d = 1'b0;
        frameErr_d  = 1'b0;
        if (fall_q) begin
            case (state_q)
                IDLE: begin
                    if (!dataBit) begin
                        state_d  = DATA;
                        bitCnt_d = '0;
                    end else begin
                        frameErr_d = 1'b1;
                    end
                end
                DATA: begin
                    shift_d  = {dataBit, shift_q[7:1]};
                    bitCnt_d = bitCnt_q + 3'd1;
                    if (bitCnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    parity_d = dataBit;
                    state_d  = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (dataBit && (^{shift_q, parity_q})) begin
                        byteValid_d = 1'b1;
                    end else begin
                        frameErr_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (timeout) begin
            state_d    = IDLE;
            shift_d    = '0;
            frameErr_d = 1'b1;
        end
    end

    assign byte_o       = shift_q;
    assign byte_valid_o = byteValid_q;
    assign frame_err_o  = frameErr_q;

endmodule

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard to ps2_key event word: frame reception plus E0/F0/E1 prefix
// tracking and emission of {toggle, pressed, ext, code}.
module ps2_key_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 12000
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] ps2_key,
    output logic        frame_err
);

    logic [7:0]  rxByte;
    logic        rxValid;
    logic        rxErr;

    logic [10:0] key_q, key_d;
    logic        ext_q, ext_d;
    logic        brk_q, brk_d;
    logic [2:0]  skip_q, skip_d;

    ps2_frame_rx #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_frame_rx (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .ps2_clk_i   (ps2_clk),
        .ps2_data_i  (ps2_data),
        .byte_o      (rxByte),
        .byte_valid_o(rxValid),
        .frame_err_o (rxErr)
    );

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            key_q  <= '0;
            ext_q  <= 1'b0;
            brk_q  <= 1'b0;
            skip_q <= '0;
        end else begin
            key_q  <= key_d;
            ext_q  <= ext_d;
            brk_q  <= brk_d;
            skip_q <= skip_d;
        end
    end

    // E1 (Pause) sequences are swallowed whole by the skip counter.
    always_comb begin
        key_d  = key_q;
        ext_d  = ext_q;
        brk_d  = brk_q;
        skip_d = skip_q;
        if (rxErr) begin
            ext_d  = 1'b0;
            brk_d  = 1'b0;
            skip_d = '0;
        end else if (rxValid) begin
            if (skip_q != 3'd0) begin
                skip_d = skip_q - 3'd1;
            end else if (rxByte == CODE_E1) begin
                skip_d = 3'd7;
                ext_d  = 1'b0;
                brk_d  = 1'b0;
            end else if (rxByte == CODE_E0) begin
                ext_d = 1'b1;
            end else if (rxByte == CODE_F0) begin
                brk_d = 1'b1;
            end else if (!(isReplyByte(rxByte) && !ext_q && !brk_q)) begin
                key_d[KEY_TOGGLE]  = ~key_q[KEY_TOGGLE];
                key_d[KEY_PRESSED] = ~brk_q;
                key_d[KEY_EXT]     = ext_q;
                key_d[7:0]         = rxByte;
                ext_d              = 1'b0;
                brk_d              = 1'b0;
            end
        end
    end

    assign ps2_key   = key_q;
    assign frame_err = rxErr;

endmodule

// File: tb/tb_ps2_key_rx.sv
// Randomised self-checking bench for ps2_key_rx against a byte-level model of
// the keyboard event protocol, plus directed prefix/error/timeout scenarios.
module tb_ps2_key_rx;

    localparam int FLEN  = 4;
    localparam int TOCYC = 200;
    localparam int HALF  = 30;
    localparam int GAP   = 60;

    localparam int K_GOOD   = 0;
    localparam int K_PARITY = 1;
    localparam int K_STOP   = 2;
    localparam int K_GLITCH = 3;
    localparam int K_PART   = 4;

    logic        clk_sys;
    logic        reset_n;
    logic        ps2Clk;
    logic        ps2Data;
    logic [10:0] ps2_key;
    logic        frame_err;

    int checks;
    int errors;
    int errPulses;
    int errCycles;
    logic errPrev;

    logic [10:0] mKey;
    logic        mExt;
    logic        mBrk;
    int          mSkip;
    int          expErr;

    ps2_key_rx #(
        .FILTER_LEN (FLEN),
        .TIMEOUT_CYC(TOCYC)
    ) dut (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .ps2_clk  (ps2Clk),
        .ps2_data (ps2Data),
        .ps2_key  (ps2_key),
        .frame_err(frame_err)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    // Counts frame_err pulses and high cycles, so pulse width is also checked.
    always @(negedge clk_sys) begin
        if (frame_err) errCycles++;
        if (frame_err && !errPrev) errPulses++;
        errPrev = frame_err;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: what a keyboard host sees per received byte.
    task automatic modelByte(input logic [7:0] b);
        if (mSkip > 0) begin
            mSkip--;
        end else if (b == 8'hE1) begin
            mSkip = 7; mExt = 0; mBrk = 0;
        end else if (b == 8'hE0) begin
            mExt = 1;
        end else if (b == 8'hF0) begin
            mBrk = 1;
        end else if (!mExt && !mBrk &&
                     (b == 8'hAA || b == 8'hFA || b == 8'hFE || b == 8'hEE || b == 8'h00 || b == 8'hFF)) begin
        end else begin
            mKey = {~mKey[10], ~mBrk, mExt, b};
            mExt = 0; mBrk = 0;
        end
    endtask

    task automatic modelErr();
        expErr++;
        mExt = 0; mBrk = 0; mSkip = 0;
    endtask

    task automatic modelReset();
        mKey = '0; mExt = 0; mBrk = 0; mSkip = 0;
    endtask

    task automatic applyStimulus(input logic [7:0] b, input int kind);
        logic [10:0] bits;
        int nBits;
        bits[0]   = 1'b0;
        bits[8:1] = b;
        bits[9]   = (~^b) ^ (kind == K_PARITY);
        bits[10]  = (kind == K_STOP) ? 1'b0 : 1'b1;
        nBits     = (kind == K_PART) ? 4 : 11;
        for (int i = 0; i < nBits; i++) begin
            ps2Data = bits[i];
            tick(HALF / 2);
            if (kind == K_GLITCH) begin
                ps2Clk = 1'b0; tick(FLEN - 2); ps2Clk = 1'b1;
            end
            tick(HALF / 2);
            ps2Clk = 1'b0;
            tick(HALF / 2);
            if (kind == K_GLITCH) begin
                ps2Clk = 1'b1; tick(FLEN - 2); ps2Clk = 1'b0;
            end
            tick(HALF / 2);
            ps2Clk = 1'b1;
        end
        ps2Data = 1'b1;
        if (kind == K_PART) begin
            tick(TOCYC + 100);
            modelErr();
        end else begin
            tick(GAP);
            if (kind == K_PARITY || kind == K_STOP) modelErr();
            else modelByte(b);
        end
    endtask

    task automatic sendChecked(input string tag, input logic [7:0] b, input int kind);
        applyStimulus(b, kind);
        checkOutput({tag, ".key"}, 32'(ps2_key), 32'(mKey));
        checkOutput({tag, ".errs"}, 32'(errPulses), 32'(expErr));
        checkOutput({tag, ".errw"}, 32'(errCycles), 32'(expErr));
    endtask

    initial begin
        logic [7:0] pick [7];
        logic [7:0] rb;
        int kind;
        int r;
        checks = 0; errors = 0; errPulses = 0; errCycles = 0; errPrev = 1'b0;
        expErr = 0;
        modelReset();
        pick[0] = 8'hE0; pick[1] = 8'hF0; pick[2] = 8'hE1; pick[3] = 8'hAA;
        pick[4] = 8'hFA; pick[5] = 8'h00; pick[6] = 8'hFF;

        reset_n = 1'b0; ps2Clk = 1'b1; ps2Data = 1'b1;
        tick(5);
        checkOutput("rst.key", 32'(ps2_key), 32'h0);
        checkOutput("rst.err", 32'(frame_err), 32'h0);
        reset_n = 1'b1;
        tick(20);

        sendChecked("t1", 8'h1C, K_GOOD);
        checkOutput("t1.lit", 32'(ps2_key), 32'h61C);

        sendChecked("t2a", 8'hF0, K_GOOD);
        sendChecked("t2b", 8'h1C, K_GOOD);
        checkOutput("t2.rel", 32'(ps2_key), 32'h01C);
        sendChecked("t2c", 8'hE0, K_GOOD);
        sendChecked("t2d", 8'h75, K_GOOD);
        checkOutput("t2.ext", 32'(ps2_key), 32'h775);
        sendChecked("t2e", 8'hE0, K_GOOD);
        sendChecked("t2f", 8'hF0, K_GOOD);
        sendChecked("t2g", 8'h75, K_GOOD);
        checkOutput("t2.extrel", 32'(ps2_key), 32'h175);

        sendChecked("t3a", 8'h1C, K_PARITY);
        checkOutput("t3.hold", 32'(ps2_key), 32'h175);
        sendChecked("t3b", 8'h1B, K_GOOD);
        checkOutput("t3.next", 32'(ps2_key), 32'h61B);

        sendChecked("t4a", 8'hE0, K_GOOD);
        sendChecked("t4b", 8'h12, K_STOP);
        sendChecked("t4c", 8'h75, K_GOOD);
        checkOutput("t4.noext", 32'(ps2_key), 32'h275);

        sendChecked("t5a", 8'h55, K_PART);
        sendChecked("t5b", 8'h29, K_GOOD);
        checkOutput("t5.after", 32'(ps2_key), 32'h629);

        sendChecked("e1a", 8'hE1, K_GOOD);
        sendChecked("e1b", 8'h14, K_GOOD);
        sendChecked("e1c", 8'h77, K_GOOD);
        sendChecked("e1d", 8'hE1, K_GOOD);
        sendChecked("e1e", 8'hF0, K_GOOD);
        sendChecked("e1f", 8'h14, K_GOOD);
        sendChecked("e1g", 8'hF0, K_GOOD);
        sendChecked("e1h", 8'h77, K_GOOD);
        checkOutput("e1.hold", 32'(ps2_key), 32'h629);
        sendChecked("aa", 8'hAA, K_GOOD);
        checkOutput("aa.hold", 32'(ps2_key), 32'h629);
        sendChecked("glitch", 8'h33, K_GLITCH);
        checkOutput("glitch.lit", 32'(ps2_key), 32'h233);

        // Lone clock pulse with data high is a bad start bit.
        ps2Data = 1'b1; tick(HALF);
        ps2Clk = 1'b0; tick(HALF); ps2Clk = 1'b1; tick(GAP);
        modelErr();
        checkOutput("start.errs", 32'(errPulses), 32'(expErr));
        checkOutput("start.key", 32'(ps2_key), 32'h233);

        for (int n = 0; n < 24; n++) begin
            r = $urandom_range(0, 9);
            rb = ($urandom_range(0, 9) < 3) ? pick[$urandom_range(0, 6)] : 8'($urandom_range(0, 255));
            kind = (r == 0) ? K_PARITY : (r == 1) ? K_STOP : (r == 2) ? K_GLITCH : K_GOOD;
            sendChecked("rnd", rb, kind);
        end

        applyStimulus(8'h5A, K_PART);
        ps2Data = 1'b0; tick(HALF); ps2Clk = 1'b0; tick(HALF / 2);
        reset_n = 1'b0;
        tick(5);
        modelReset();
        checkOutput("mrst.key", 32'(ps2_key), 32'h0);
        checkOutput("mrst.err", 32'(frame_err), 32'h0);
        ps2Clk = 1'b1; ps2Data = 1'b1;
        tick(5);
        reset_n = 1'b1;
        tick(TOCYC + 50);
        checkOutput("mrst.hold", 32'(ps2_key), 32'h0);
        checkOutput("mrst.errs", 32'(errPulses), 32'(expErr));
        sendChecked("post", 8'h1C, K_GOOD);
        checkOutput("post.lit", 32'(ps2_key), 32'h61C);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_key_rx.md
Name: ps2_key_rx

Overview:
Decodes a raw PS/2 keyboard line (device-to-host clock and data) into the 11-bit ps2_key event word consumed by core top levels.
- Word format: [10] toggle, [9] pressed, [8] extended (E0), [7:0] scan code.
- Used where a physical keyboard drives the core directly instead of the HPS.
- Contains input synchronisation, glitch filtering, frame reception, E0/F0 prefix tracking and event emission.

Parameters:
FILTER_LEN, 8, consecutive clk_sys samples a synchronised ps2_clk level must hold before it is accepted (range 2..255).
TIMEOUT_CYC, 12000, clk_sys cycles without an accepted ps2_clk falling edge before a partial frame is discarded.

Ports:
clk_sys  input  1  system clock; all logic on its rising edge.
reset_n  input  1  asynchronous active-low reset.
ps2_clk  input  1  raw PS/2 clock, asynchronous to clk_sys.
ps2_data  input  1  raw PS/2 data, asynchronous to clk_sys.
ps2_key  output  11  event word: {toggle, pressed, ext, code[7:0]}.
frame_err  output  1  one-cycle pulse on parity error, bad start bit, bad stop bit or timeout.

Behaviour:
- Reset: one clock, clk_sys; reset is asynchronous and active-low (reset_n). While reset_n=0, all state clears:
  - ps2_key=11'h000, frame_err=0, FSM=IDLE.
  - ext and brk flags clear; E1 skip counter = 0; filtered clock = 1.
- Synchronisation: ps2_clk and ps2_data each pass through 2 flops.
  - The filtered clock changes only after FILTER_LEN consecutive equal synchronised samples.
  - An accepted 1->0 transition of the filtered clock is a "fall" strobe, one cycle wide.
  - Data is sampled from synchronised ps2_data on the fall strobe.
- Frame FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on fall with data=0 -> DATA, bit count 0. Fall with data=1 -> frame_err pulse, stay IDLE.
  - DATA: shift LSB first. After the 8th bit -> PARITY.
  - PARITY: capture the bit; odd parity over 8 data bits plus parity is required -> STOP.
  - STOP: the stop bit must be 1.
    - Good frame: byte_valid pulses for 1 cycle in the cycle after this fall.
    - Bad stop bit or bad parity: frame_err pulses in that same cycle, no byte_valid. In either case -> IDLE.
  - Timeout counter resets on every fall. When it reaches TIMEOUT_CYC in any state other than IDLE: frame_err pulse, -> IDLE, shift register discarded.
- Byte decoder (acts on byte_valid):
  - If E1 skip counter > 0: decrement, no event.
  - 8'hE1: load skip counter with 7, clear ext and brk.
  - 8'hE0: set ext. 8'hF0: set brk.
  - 8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF with ext=0 and brk=0: ignored, no event.
  - Any other byte: ps2_key <= {~ps2_key[10], ~brk, ext, byte}, then clear ext and brk.
- Latency: ps2_key updates exactly 1 cycle after byte_valid, i.e. 2 cycles after the stop-bit fall strobe. ps2_key holds its value between events.
- frame_err clears ext, brk and the E1 skip counter.
- A frame error never toggles ps2_key[10].
- Toggle wraps naturally: 1 -> 0 on the next event.
- Simultaneous timeout and fall in the same cycle: the fall wins and the counter restarts.
- Reset asserted mid-frame: the partial frame is discarded and no event is emitted after reset release.
- Width rules:
  - Bit counter is 3 bits.
  - Timeout counter is $clog2(TIMEOUT_CYC+1) bits and saturates.
  - Filter counter is $clog2(FILTER_LEN+1) bits.

Decomposition:
- Package ps2_pkg holds:
  - Prefix/reply byte constants: E0, E1, F0, AA, FA, FE, EE.
  - The ps2_key bit-index localparams: TOGGLE=10, PRESSED=9, EXT=8.
  - Frame state enum {IDLE, DATA, PARITY, STOP}.
- One sub-module, ps2_frame_rx, covers sync, filter, frame FSM and timeout. It outputs byte, byte_valid and frame_err.
- The prefix decoder and ps2_key register stay in ps2_key_rx.

Test Plan:
1. Reset, then a good frame with byte 8'h1C at 12.5 kHz -> ps2_key=11'h61C; frame_err never asserted.
2. Continue with F0 then 1C -> ps2_key=11'h01C (toggle 0, released). Then E0 75 -> 11'h775. Then E0 F0 75 -> 11'h175.
3. Frame 8'h1C with parity inverted -> frame_err single pulse, ps2_key unchanged. Following frame 8'h1B -> toggle flips, ps2_key[8:0]=9'h01B.
4. Send E0, then a frame with a bad stop bit, then 8'h75 -> 8'h75 decodes with ext=0 (flag cleared by the error).
5. 4 bits of a frame, then silence > TIMEOUT_CYC -> one frame_err pulse. Next full frame 8'h29 decodes correctly.
6. Remaining cases:
   - E1 14 77 E1 F0 14 F0 77 -> no ps2_key change.
   - 8'hAA alone -> no change.
   - Glitch pulses of ps2_clk shorter than FILTER_LEN cycles mid-frame -> no extra bits, byte decodes correctly.
   - reset_n low mid-frame -> all outputs 0.
